window_avg_absdiff: RTL and testbench
=====================================

WINDOW_AVG_ABSDIFF -- requirements
Module: window_avg_absdiff

Interface
REQ-001 Parameter W, default 8: sample width in bits, at least 2.
REQ-002 Parameter LOG2N, default 2: log2 of the window length N = 2^LOG2N samples, 1..6.
REQ-003 Parameter SLIDING, default 0: 0 = non-overlapping block windows, 1 = sliding window.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  in_data carries a sample this cycle.
REQ-007 in_data  in  W  unsigned sample.
REQ-008 in_ready  out  1  block accepts a sample this cycle.
REQ-009 out_valid  out  1  avg_out and diff_out hold an unconsumed result.
REQ-010 out_ready  in  1  consumer takes the result this cycle.
REQ-011 avg_out  out  W  window average.
REQ-012 diff_out  out  W  absolute difference between avg_out and the newest sample of that window.
REQ-013 idle  out  1  no samples held in the current window and out_valid low.

Function
REQ-014 in_ready SHALL be combinational: in_ready = !out_valid || out_ready.
REQ-015 A sample SHALL be accepted exactly when in_valid && in_ready && !rst.
REQ-016 The block SHALL hold a sample count 0..N, a running sum of width W+LOG2N that never overflows, and, when SLIDING=1, an N-entry sample FIFO.
REQ-017 Block mode: each accepted sample SHALL add to the sum and increment the count.
REQ-018 Block mode: the Nth accepted sample SHALL complete the window, then clear the count and sum in the same edge.
REQ-019 Sliding mode: each accepted sample SHALL push the FIFO and add in_data to the sum.
REQ-020 Sliding mode: once the count equals N, each accepted sample SHALL also subtract the evicted oldest sample; the count saturates at N.
REQ-021 Sliding mode: every accepted sample that leaves N samples in the window SHALL complete a window.
REQ-022 On window completion: total = sum of the N window samples including the current in_data; avg = total >> LOG2N, floor, no rounding.
REQ-023 On window completion: diff = avg - in_data if avg >= in_data, else in_data - avg.
REQ-024 avg and diff SHALL be registered into avg_out and diff_out, and out_valid set, on the edge that accepts the completing sample (latency 1 cycle).
REQ-025 out_valid SHALL clear on an edge with out_valid && out_ready and no new completion.
REQ-026 A completion in the same cycle as consumption SHALL keep out_valid high with the new result.
REQ-027 avg_out and diff_out SHALL hold their values between completions, including after consumption.
REQ-028 While out_valid && !out_ready, in_ready SHALL be low, no sample is accepted, and all window state is frozen.
REQ-029 in_data SHALL be ignored whenever in_valid is low.
REQ-030 idle = (count == 0) && !out_valid. In sliding mode, idle stays low after the first accepted sample until reset.

Reset
REQ-031 While rst is high: count, sum and FIFO entries SHALL clear to 0; avg_out = 0, diff_out = 0, out_valid = 0.
REQ-032 While rst is high, no samples SHALL be accepted.
REQ-033 Reset mid-window SHALL discard all partial window samples; the first sample accepted after rst deasserts starts a new window.
REQ-034 Reset SHALL drop a pending unconsumed result.

Verification (W=8, LOG2N=2 unless stated; out_ready=1 unless stated)
REQ-035 Block: 10, 20, 30, 40 -> one cycle after 40: out_valid=1, avg_out=25, diff_out=15; idle=1 after consumption.
REQ-036 Extremes: 255 four times -> avg_out=255, diff_out=0; sum 1020 with no overflow. Then 100, 100, 100, 0 -> avg_out=75, diff_out=75.
REQ-037 Backpressure: after a result, hold out_ready=0 -> in_ready=0 and offered samples are not accepted; outputs are held. Raise out_ready -> out_valid clears and the next four samples form a fresh window.
REQ-038 Sliding (SLIDING=1): 4, 8, 12, 16, 20 -> no result for the first three samples. After 16: avg_out=10, diff_out=6. After 20: avg_out=14, diff_out=6, out_valid high on consecutive cycles.
REQ-039 Reset mid-window: 7, 9, then rst for 1 cycle, then 1, 2, 3, 4 -> avg_out=2, diff_out=2; no result from the discarded samples.
REQ-040 Gapped input: 10, 20, 30, 40 with in_valid low for 2 cycles between samples and in_data=0xFF during the gaps -> avg_out=25, diff_out=15.

Source files
------------

// File: rtl/window_avg_absdiff.sv
// Windowed average of an unsigned sample stream, plus the absolute difference
// between that average and the newest sample of the window. Works either on
// non-overlapping blocks of N samples or on a sliding window of the last N.
module window_avg_absdiff #(
  parameter int W       = 8,
  parameter int LOG2N   = 2,
  parameter bit SLIDING = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] avg_out,
  output logic [W-1:0] diff_out,
  output logic         idle
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = W + LOG2N;   // holds N full-scale samples exactly
  localparam int CW = LOG2N + 1;   // count range 0..N
  localparam logic [CW-1:0] N_C = CW'(N);

  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  avg_q, avg_d;
  logic [W-1:0]  diff_q, diff_d;

  logic          accept;
  logic          complete;
  logic          full;
  logic [SW-1:0] evict_sub;   // oldest sample leaving the window, or 0
  logic [SW-1:0] total;       // window sum including the current sample
  logic [W-1:0]  avg_new;
  logic [W-1:0]  diff_new;

  // A new sample may enter unless an unconsumed result is being held.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !rst;
  assign full     = (count_q == N_C);

  generate
    if (SLIDING) begin : g_fifo
      logic [W-1:0]       fifo_q [N];
      logic [LOG2N-1:0]   wr_ptr_q;

      // Once the window is full, the write slot holds the oldest sample.
      assign evict_sub = full ? SW'(fifo_q[wr_ptr_q]) : '0;

      // Circular sample history; overwritten in arrival order.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++) fifo_q[i] <= '0;
          wr_ptr_q <= '0;
        end else if (accept) begin
          fifo_q[wr_ptr_q] <= in_data;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
      end
    end else begin : g_no_fifo
      assign evict_sub = '0;
    end
  endgenerate

  // Modular arithmetic is fine here: the true window sum always fits in SW bits.
  assign total    = sum_q + SW'(in_data) - evict_sub;
  assign avg_new  = total[SW-1:LOG2N];
  assign diff_new = (avg_new >= in_data) ? (avg_new - in_data) : (in_data - avg_new);

  // Window bookkeeping and result/handshake next state.
  always_comb begin
    count_d  = count_q;
    sum_d    = sum_q;
    complete = 1'b0;
    valid_d  = valid_q;
    avg_d    = avg_q;
    diff_d   = diff_q;

    if (accept) begin
      if (SLIDING) begin
        sum_d    = total;
        complete = (count_q >= N_C - 1'b1);
        if (!full) count_d = count_q + 1'b1;
      end else if (count_q == N_C - 1'b1) begin
        complete = 1'b1;
        count_d  = '0;
        sum_d    = '0;
      end else begin
        count_d = count_q + 1'b1;
        sum_d   = total;
      end
    end

    if (complete) begin
      valid_d = 1'b1;
      avg_d   = avg_new;
      diff_d  = diff_new;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards the partial window and any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      diff_q  <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      avg_q   <= avg_d;
      diff_q  <= diff_d;
    end
  end

  assign out_valid = valid_q;
  assign avg_out   = avg_q;
  assign diff_out  = diff_q;
  assign idle      = (count_q == '0) && !valid_q;

endmodule

// File: tb/tb_window_avg_absdiff.sv
// Bench for window_avg_absdiff: a block-mode and a sliding-mode instance share
// the same stimulus; directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_window_avg_absdiff;

  localparam int W = 8;
  localparam int LOG2N = 2;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic       rdy_o  [2];
  logic       vld_o  [2];
  logic [7:0] avg_o  [2];
  logic [7:0] diff_o [2];
  logic       idle_o [2];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: window contents as queues, result registers as ints.
  int q0[$];
  int q1[$];
  bit m_valid [2];
  int m_avg   [2];
  int m_diff  [2];
  bit exp_rdy [2];
  bit obs_rdy [2];

  always #5 clk = ~clk;

  window_avg_absdiff #(.W(W), .LOG2N(LOG2N), .SLIDING(1'b0)) u_blk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_o[0]), .out_valid(vld_o[0]), .out_ready(out_ready),
    .avg_out(avg_o[0]), .diff_out(diff_o[0]), .idle(idle_o[0])
  );

  window_avg_absdiff #(.W(W), .LOG2N(LOG2N), .SLIDING(1'b1)) u_sld (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_o[1]), .out_valid(vld_o[1]), .out_ready(out_ready),
    .avg_out(avg_o[1]), .diff_out(diff_o[1]), .idle(idle_o[1])
  );

  function automatic int wsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_update(input int m, input bit acc, input int d, input bit r, input bit ordy);
    bit comp;
    int tot;
    comp = 1'b0;
    tot  = 0;
    if (acc) begin
      if (m == 0) begin
        q0.push_back(d);
        if (q0.size() == N) begin
          comp = 1'b1;
          foreach (q0[i]) tot += q0[i];
          q0.delete();
        end
      end else begin
        q1.push_back(d);
        if (q1.size() > N) void'(q1.pop_front());
        if (q1.size() == N) begin
          comp = 1'b1;
          foreach (q1[i]) tot += q1[i];
        end
      end
    end
    if (r) begin
      if (m == 0) q0.delete(); else q1.delete();
      m_valid[m] = 1'b0;
      m_avg[m]   = 0;
      m_diff[m]  = 0;
    end else if (comp) begin
      m_valid[m] = 1'b1;
      m_avg[m]   = tot / N;
      m_diff[m]  = (m_avg[m] >= d) ? m_avg[m] - d : d - m_avg[m];
    end else if (m_valid[m] && ordy) begin
      m_valid[m] = 1'b0;
    end
  endtask

  // One clock cycle: drive, sample in_ready before the edge, advance model.
  task automatic tick(input bit v, input int d, input bit ordy);
    in_valid  = v;
    in_data   = d[7:0];
    out_ready = ordy;
    #2;
    for (int k = 0; k < 2; k++) begin
      obs_rdy[k] = rdy_o[k];
      exp_rdy[k] = !m_valid[k] || ordy;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      model_update(k, v && exp_rdy[k] && !rst, d, rst, ordy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1, 8'hAA, 1);
    tick(1, 8'h55, 1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (vld_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %0d expected 0", k, vld_o[k]); end
      n_cmp++;
      if (avg_o[k] !== 8'd0 || diff_o[k] !== 8'd0) begin
        n_fail++; $display("FAIL reset_outs[%0d]: got avg=%0d diff=%0d expected 0/0", k, avg_o[k], diff_o[k]);
      end
      n_cmp++;
      if (idle_o[k] !== 1'b1) begin n_fail++; $display("FAIL reset_idle[%0d]: got %0d expected 1", k, idle_o[k]); end
      n_cmp++;
      if (obs_rdy[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %0d expected 1", k, obs_rdy[k]); end
    end
    $display("test_reset: done");
  endtask

  task automatic test_block();
    int s [4] = '{10, 20, 30, 40};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, s[i], 1);
      if (i < 3) begin
        n_cmp++;
        if (vld_o[0] !== 1'b0) begin n_fail++; $display("FAIL block_early[%0d]: got valid=%0d expected 0", i, vld_o[0]); end
      end
    end
    n_cmp++;
    if (vld_o[0] !== 1'b1 || avg_o[0] !== 8'd25 || diff_o[0] !== 8'd15) begin
      n_fail++; $display("FAIL block_result: got v=%0d avg=%0d diff=%0d expected 1/25/15", vld_o[0], avg_o[0], diff_o[0]);
    end
    tick(0, 0, 1);
    n_cmp++;
    if (idle_o[0] !== 1'b1 || vld_o[0] !== 1'b0 || avg_o[0] !== 8'd25) begin
      n_fail++; $display("FAIL block_consumed: got idle=%0d v=%0d avg=%0d expected 1/0/25", idle_o[0], vld_o[0], avg_o[0]);
    end
    n_cmp++;
    if (idle_o[1] !== 1'b0) begin n_fail++; $display("FAIL sliding_idle: got %0d expected 0", idle_o[1]); end
    $display("test_block: avg=%0d diff=%0d", avg_o[0], diff_o[0]);
  endtask

  task automatic test_extremes();
    int s [4] = '{100, 100, 100, 0};
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 255, 1);
    n_cmp++;
    if (avg_o[0] !== 8'd255 || diff_o[0] !== 8'd0) begin
      n_fail++; $display("FAIL extreme_max: got avg=%0d diff=%0d expected 255/0", avg_o[0], diff_o[0]);
    end
    for (int i = 0; i < 4; i++) tick(1, s[i], 1);
    n_cmp++;
    if (vld_o[0] !== 1'b1 || avg_o[0] !== 8'd75 || diff_o[0] !== 8'd75) begin
      n_fail++; $display("FAIL extreme_zero: got v=%0d avg=%0d diff=%0d expected 1/75/75", vld_o[0], avg_o[0], diff_o[0]);
    end
    $display("test_extremes: avg=%0d diff=%0d", avg_o[0], diff_o[0]);
  endtask

  task automatic test_backpressure();
    int s [4] = '{50, 60, 70, 80};
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1, i, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 99, 0);
      n_cmp++;
      if (obs_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0d expected 0", i, obs_rdy[0]); end
      n_cmp++;
      if (vld_o[0] !== 1'b1 || avg_o[0] !== 8'd2 || diff_o[0] !== 8'd2) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0d avg=%0d diff=%0d expected 1/2/2", i, vld_o[0], avg_o[0], diff_o[0]);
      end
    end
    tick(0, 0, 1);
    n_cmp++;
    if (vld_o[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid=%0d expected 0", vld_o[0]); end
    for (int i = 0; i < 4; i++) tick(1, s[i], 1);
    n_cmp++;
    if (vld_o[0] !== 1'b1 || avg_o[0] !== 8'd65 || diff_o[0] !== 8'd15) begin
      n_fail++; $display("FAIL bp_fresh: got v=%0d avg=%0d diff=%0d expected 1/65/15", vld_o[0], avg_o[0], diff_o[0]);
    end
    $display("test_backpressure: avg=%0d diff=%0d", avg_o[0], diff_o[0]);
  endtask

  task automatic test_sliding();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick(1, 4 * i, 1);
      n_cmp++;
      if (vld_o[1] !== 1'b0) begin n_fail++; $display("FAIL slide_early[%0d]: got valid=%0d expected 0", i, vld_o[1]); end
    end
    tick(1, 16, 1);
    n_cmp++;
    if (vld_o[1] !== 1'b1 || avg_o[1] !== 8'd10 || diff_o[1] !== 8'd6) begin
      n_fail++; $display("FAIL slide_first: got v=%0d avg=%0d diff=%0d expected 1/10/6", vld_o[1], avg_o[1], diff_o[1]);
    end
    tick(1, 20, 1);
    n_cmp++;
    if (vld_o[1] !== 1'b1 || avg_o[1] !== 8'd14 || diff_o[1] !== 8'd6) begin
      n_fail++; $display("FAIL slide_second: got v=%0d avg=%0d diff=%0d expected 1/14/6", vld_o[1], avg_o[1], diff_o[1]);
    end
    n_cmp++;
    if (vld_o[0] !== 1'b0) begin n_fail++; $display("FAIL slide_blk_clear: got valid=%0d expected 0", vld_o[0]); end
    $display("test_sliding: avg=%0d diff=%0d", avg_o[1], diff_o[1]);
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1, 7, 1);
    tick(1, 9, 1);
    rst = 1'b1;
    tick(0, 0, 1);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(1, i, 1);
      n_cmp++;
      if (vld_o[0] !== 1'b0 || vld_o[1] !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_early[%0d]: got valid=%0d/%0d expected 0/0", i, vld_o[0], vld_o[1]);
      end
    end
    tick(1, 4, 1);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (vld_o[k] !== 1'b1 || avg_o[k] !== 8'd2 || diff_o[k] !== 8'd2) begin
        n_fail++; $display("FAIL rstmid_result[%0d]: got v=%0d avg=%0d diff=%0d expected 1/2/2", k, vld_o[k], avg_o[k], diff_o[k]);
      end
    end
    $display("test_reset_mid: avg=%0d diff=%0d", avg_o[0], diff_o[0]);
  endtask

  task automatic test_gapped();
    int s [4] = '{10, 20, 30, 40};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, s[i], 1);
      if (i < 3) begin
        tick(0, 255, 1);
        tick(0, 255, 1);
      end
    end
    n_cmp++;
    if (vld_o[0] !== 1'b1 || avg_o[0] !== 8'd25 || diff_o[0] !== 8'd15) begin
      n_fail++; $display("FAIL gapped: got v=%0d avg=%0d diff=%0d expected 1/25/15", vld_o[0], avg_o[0], diff_o[0]);
    end
    $display("test_gapped: avg=%0d diff=%0d", avg_o[0], diff_o[0]);
  endtask

  task automatic test_random();
    int d;
    int bad;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = 255;
        default: d = $urandom_range(0, 255);
      endcase
      tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7);
      bad = 0;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_rdy[k] !== exp_rdy[k] || vld_o[k] !== m_valid[k] || avg_o[k] !== 8'(m_avg[k]) ||
            diff_o[k] !== 8'(m_diff[k]) || idle_o[k] !== (wsize(k) == 0 && !m_valid[k])) begin
          n_fail++; bad++;
          $display("FAIL random[%0d] c=%0d: got rdy=%0d v=%0d avg=%0d diff=%0d idle=%0d expected %0d/%0d/%0d/%0d/%0d",
                   k, c, obs_rdy[k], vld_o[k], avg_o[k], diff_o[k], idle_o[k],
                   exp_rdy[k], m_valid[k], m_avg[k], m_diff[k], (wsize(k) == 0 && !m_valid[k]));
        end
      end
    end
    rst = 1'b0;
    $display("test_random: 400 cycles checked");
  endtask

  initial begin
    test_reset();
    test_block();
    test_extremes();
    test_backpressure();
    test_sliding();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
